// File: rtl/plp_bus_pkg.sv
// Shared bus-initiator definitions: command encodings, word stride, DMA state enum.
package plp_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DRW_W  = 2;

  localparam logic [DRW_W-1:0]  DRW_NOP   = 2'b00;
  localparam logic [DRW_W-1:0]  DRW_WRITE = 2'b01;
  localparam logic [DRW_W-1:0]  DRW_READ  = 2'b10;

  localparam logic [ADDR_W-1:0] WORD_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  // One initiator beat as driven onto the bus.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DRW_W-1:0]  drw;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/bus_dma_master.sv
// Second bus initiator copying a block of words read-then-write, ascending,
// with a one-cycle done pulse on completion or abort.
module bus_dma_master
  import plp_bus_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] bus_daddr,
  output logic [DRW_W-1:0]  bus_drw,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_stall,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     remaining
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CW-1:0]     rem_q, rem_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              to_done;

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; the output registers are loaded with the values of the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    to_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            src_d      = word_align(src_addr);
            dst_d      = word_align(dst_addr);
            rem_d      = count;
            cmd_d.addr = word_align(src_addr);
            cmd_d.drw  = DRW_READ;
            busy_d     = 1'b1;
            state_d    = ST_READ;
          end else begin
            to_done = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (abort) begin
          to_done = 1'b1;
        end else if (!bus_stall) begin
          src_d       = src_q + WORD_STRIDE;
          cmd_d.wdata = bus_rdata;
          cmd_d.addr  = dst_q;
          cmd_d.drw   = DRW_WRITE;
          state_d     = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (abort) begin
          to_done = 1'b1;
        end else if (!bus_stall) begin
          dst_d = dst_q + WORD_STRIDE;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            to_done = 1'b1;
          end else begin
            cmd_d.addr = src_q;
            cmd_d.drw  = DRW_READ;
            state_d    = ST_READ;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        src_d   = '0;
        dst_d   = '0;
        rem_d   = '0;
        cmd_d   = '0;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    // Completion or abort: bus goes quiet, remaining keeps the unwritten count.
    if (to_done) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cmd_d   = '0;
    end
  end

  assign bus_daddr = cmd_q.addr;
  assign bus_drw   = cmd_q.drw;
  assign bus_wdata = cmd_q.wdata;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master: per-cycle expected trace built from the copy rules,
// checked every cycle, plus literal checks on logged bus traffic and done timing.
module tb_bus_dma_master;

  localparam int unsigned CW = 16;
  localparam logic [1:0] E_NOP = 2'b00;
  localparam logic [1:0] E_WR  = 2'b01;
  localparam logic [1:0] E_RD  = 2'b10;

  logic          clk = 1'b0;
  logic          rst, start, abort, bus_stall;
  logic [31:0]   src_addr, dst_addr, bus_daddr, bus_wdata, bus_rdata;
  logic [CW-1:0] count, remaining;
  logic [1:0]    bus_drw;
  logic          busy, done;

  always #5 clk = ~clk;

  bus_dma_master #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .bus_daddr (bus_daddr),
    .bus_drw   (bus_drw),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_stall (bus_stall),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  // Zero-wait memory: four known words at 0x10000000, an address hash elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a >= 32'h1000_0000 && a < 32'h1000_0010) return 32'hA + ((a - 32'h1000_0000) >> 2);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign bus_rdata = mem_fn(bus_daddr);

  typedef struct {
    logic          first, start, abort, stall, rstn;
    logic [1:0]    drw;
    logic [31:0]   addr, wdata;
    logic          busy, done;
    logic [CW-1:0] rem;
    logic          chk_addr, chk_wdata;
  } ent_t;

  ent_t          q[$];
  ent_t          cur;
  logic          chk_en = 1'b0;
  int            tests = 0, fails = 0;
  logic [31:0]   cfg_src, cfg_dst;
  logic [CW-1:0] cfg_cnt;
  int            rs[8], ws[8];
  int            ab_w, ab_wr, rst_w;
  bit            mid_start;
  int            cyc, done_cyc, done_cnt;
  logic [CW-1:0] done_rem;
  logic [31:0]   rd_log[$];
  logic [63:0]   wr_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [1:0] drw, input logic [31:0] addr, input logic [31:0] wd,
                              input logic bsy, input logic dn, input logic [CW-1:0] rem,
                              input logic ca, input logic cw);
    ent_t e;
    e.first = 1'b0; e.start = 1'b0; e.abort = 1'b0; e.stall = 1'b0; e.rstn = 1'b1;
    e.drw = drw; e.addr = addr; e.wdata = wd; e.busy = bsy; e.done = dn; e.rem = rem;
    e.chk_addr = ca; e.chk_wdata = cw;
    return e;
  endfunction

  function automatic logic [63:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 32'h1234_5678;
  endfunction

  task automatic clr_cfg();
    for (int i = 0; i < 8; i++) begin rs[i] = 0; ws[i] = 0; end
    ab_w = -1; ab_wr = 0; rst_w = -1; mid_start = 1'b0;
    rd_log.delete(); wr_log.delete();
    done_cnt = 0; done_cyc = -1; done_rem = '1;
  endtask

  // Expected trace of one copy: one entry per cycle, from the start cycle to the idle cycle after.
  task automatic gen();
    ent_t          e;
    logic [31:0]   sa, da, wd;
    logic [CW-1:0] rem;
    bit            stop;
    e = mk(E_NOP, 0, 0, 0, 0, 0, 1, 1);
    e.first = 1'b1; e.start = 1'b1;
    q.push_back(e);
    sa = cfg_src & ~32'h3; da = cfg_dst & ~32'h3; rem = cfg_cnt; stop = 1'b0;
    for (int i = 0; i < int'(cfg_cnt) && !stop; i++) begin
      for (int s = 0; s <= rs[i]; s++) begin
        e = mk(E_RD, sa, 0, 1, 0, rem, 1, 0);
        e.stall = (s < rs[i]);
        e.start = mid_start && (i == 1);
        if (rst_w == i && s == 0) begin
          e.rstn = 1'b0;
          q.push_back(e);
          q.push_back(mk(E_NOP, 0, 0, 0, 0, 0, 1, 1));
          return;
        end
        if (ab_w == i && ab_wr == 0 && s == 0) begin e.abort = 1'b1; stop = 1'b1; end
        q.push_back(e);
        if (stop) break;
      end
      if (stop) break;
      wd = mem_fn(sa);
      sa = sa + 32'd4;
      for (int s = 0; s <= ws[i]; s++) begin
        e = mk(E_WR, da, wd, 1, 0, rem, 1, 1);
        e.stall = (s < ws[i]);
        e.start = mid_start && (i == 1);
        if (ab_w == i && ab_wr == 1 && s == 0) begin e.abort = 1'b1; stop = 1'b1; end
        q.push_back(e);
        if (stop) break;
      end
      if (stop) break;
      da = da + 32'd4;
      rem = rem - CW'(1);
    end
    e = mk(E_NOP, 0, 0, 0, 1, rem, 0, 0);
    e.start = mid_start;
    q.push_back(e);
    q.push_back(mk(E_NOP, 0, 0, 0, 0, 0, 1, 1));
  endtask

  // Presents each entry's inputs for one cycle; addresses/count are junk except in the start cycle.
  task automatic play();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      cur       = q.pop_front();
      rst       = cur.rstn;
      start     = cur.start;
      abort     = cur.abort;
      bus_stall = cur.stall;
      src_addr  = cur.first ? cfg_src : ~cfg_src;
      dst_addr  = cur.first ? cfg_dst : ~cfg_dst;
      count     = cur.first ? cfg_cnt : cfg_cnt + CW'(5);
      chk_en    = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b0; abort = 1'b0; bus_stall = 1'b0;
  endtask

  // Per-cycle compare against the expected trace, plus traffic/done logging.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("drw", 64'(bus_drw), 64'(cur.drw));
      chk("busy", 64'(busy), 64'(cur.busy));
      chk("done", 64'(done), 64'(cur.done));
      chk("remaining", 64'(remaining), 64'(cur.rem));
      if (cur.chk_addr) chk("daddr", 64'(bus_daddr), 64'(cur.addr));
      if (cur.chk_wdata) chk("wdata", 64'(bus_wdata), 64'(cur.wdata));
      if (cur.first) cyc = 0;
      else cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; done_rem = remaining; end
      if (cur.rstn && !cur.abort && !cur.stall) begin
        if (bus_drw == E_RD) rd_log.push_back(bus_daddr);
        if (bus_drw == E_WR) wr_log.push_back({bus_daddr, bus_wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; bus_stall = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0;
    cfg_src = '0; cfg_dst = '0; cfg_cnt = '0;

    // Reset state
    clr_cfg();
    repeat (2) begin
      cur = mk(E_NOP, 0, 0, 0, 0, 0, 1, 1);
      cur.rstn = 1'b0;
      q.push_back(cur);
    end
    play();

    // Basic copy
    clr_cfg();
    cfg_src = 32'h1000_0000; cfg_dst = 32'h1000_0100; cfg_cnt = CW'(3);
    gen(); play();
    chk("basic_done_cycle", 64'(done_cyc), 64'd7);
    chk("basic_done_rem", 64'(done_rem), 64'd0);
    chk("basic_wr0", wr_at(0), {32'h1000_0100, 32'hA});
    chk("basic_wr1", wr_at(1), {32'h1000_0104, 32'hB});
    chk("basic_wr2", wr_at(2), {32'h1000_0108, 32'hC});
    chk("basic_rd2", 64'(rd_at(2)), 64'h1000_0008);

    // Stall handling
    clr_cfg();
    cfg_src = 32'h1000_0004; cfg_dst = 32'h2000_0000; cfg_cnt = CW'(1);
    rs[0] = 2; ws[0] = 1;
    gen(); play();
    chk("stall_done_cycle", 64'(done_cyc), 64'd6);
    chk("stall_wr0", wr_at(0), {32'h2000_0000, 32'hB});

    // Zero count
    clr_cfg();
    cfg_src = 32'h1000_0000; cfg_dst = 32'h2000_0000; cfg_cnt = '0;
    gen(); play();
    chk("zero_done_cycle", 64'(done_cyc), 64'd1);
    chk("zero_traffic", 64'(rd_log.size() + wr_log.size()), 64'd0);

    // Start pulsed mid-copy and in the done cycle is ignored
    clr_cfg();
    cfg_src = 32'h1000_0008; cfg_dst = 32'h3000_0000; cfg_cnt = CW'(2);
    mid_start = 1'b1;
    gen(); play();
    chk("midstart_wr0", wr_at(0), {32'h3000_0000, 32'hC});
    chk("midstart_wr1", wr_at(1), {32'h3000_0004, 32'hD});
    chk("midstart_done_cnt", 64'(done_cnt), 64'd1);

    // Abort during stalled second write
    clr_cfg();
    cfg_src = 32'h1000_0000; cfg_dst = 32'h5000_0000; cfg_cnt = CW'(4);
    ws[1] = 2; ab_w = 1; ab_wr = 1;
    gen(); play();
    chk("abort_nwr", 64'(wr_log.size()), 64'd1);
    chk("abort_wr0", wr_at(0), {32'h5000_0000, 32'hA});
    chk("abort_rem", 64'(done_rem), 64'd3);
    chk("abort_done_cnt", 64'(done_cnt), 64'd1);
    chk("abort_done_cycle", 64'(done_cyc), 64'd5);

    // Wrap and alignment
    clr_cfg();
    cfg_src = 32'hFFFF_FFFE; cfg_dst = 32'h4000_0001; cfg_cnt = CW'(2);
    gen(); play();
    chk("wrap_rd0", 64'(rd_at(0)), 64'hFFFF_FFFC);
    chk("wrap_rd1", 64'(rd_at(1)), 64'h0000_0000);
    chk("wrap_wr0", wr_at(0), {32'h4000_0000, 32'h2152_4113});
    chk("wrap_wr1", wr_at(1), {32'h4000_0004, 32'hDEAD_BEEF});

    // Reset during read of word 2
    clr_cfg();
    cfg_src = 32'h1000_0000; cfg_dst = 32'h6000_0000; cfg_cnt = CW'(3);
    rst_w = 1;
    gen(); play();
    chk("rstmid_done_cnt", 64'(done_cnt), 64'd0);
    chk("rstmid_nwr", 64'(wr_log.size()), 64'd1);

    // Normal copy after reset
    clr_cfg();
    cfg_src = 32'h1000_000C; cfg_dst = 32'h7000_0000; cfg_cnt = CW'(1);
    gen(); play();
    chk("postrst_done_cycle", 64'(done_cyc), 64'd3);
    chk("postrst_wr0", wr_at(0), {32'h7000_0000, 32'hD});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_dma_master.md
# bus_dma_master

Bus initiator that copies a block of 32-bit words from one bus address range to another using the same initiator protocol the CPU drives into the arbiter: a word-aligned address, a 2-bit read/write command, write data out and read data in, qualified by a stall signal. It sits beside the CPU as a second initiator. An external mux, outside this block, selects it onto the arbiter's data port while `busy` is high. Completion is reported with a one-cycle `done` pulse suitable as an interrupt source for `mod_interrupt`.

## Interface
- `CW`, default 16: width of the word-count input and the remaining-count output.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `start`  in  1  request a copy; sampled only in IDLE.
- `abort`  in  1  cancel the copy in progress; sampled in READ and WRITE.
- `src_addr`  in  32  source byte address; bits [1:0] ignored (treated as 0).
- `dst_addr`  in  32  destination byte address; bits [1:0] ignored.
- `count`  in  CW  number of words to copy.
- `bus_daddr`  out  32  initiator address, word aligned.
- `bus_drw`  out  2  command: 00 nop, 01 write, 10 read. 11 is never driven.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  read data; combinational from the responder in the same cycle.
- `bus_stall`  in  1  responder stall; the current command is held while it is high.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `remaining`  out  CW  words not yet written.

## Operation
- States are IDLE, READ, WRITE and DONE. Reset forces IDLE.
- All outputs are 0 in reset and in IDLE: `bus_drw`=00, `bus_daddr`=0, `bus_wdata`=0, `busy`=0, `done`=0, `remaining`=0.
- **IDLE, `start`=1 and `count`≠0:** latch `src_addr`&~3, `dst_addr`&~3 and `count` into the src pointer, dst pointer and remaining counter. Go to READ.
- **IDLE, `start`=1 and `count`=0:** go straight to DONE. No bus traffic.
- **READ:** drive `bus_drw`=10 and `bus_daddr`=src pointer.
  - On an edge with `bus_stall`=0: latch `bus_rdata` into the data register, add 4 to src, go to WRITE.
  - On an edge with `bus_stall`=1: hold the state and all outputs.
- **WRITE:** drive `bus_drw`=01, `bus_daddr`=dst pointer, `bus_wdata`=data register.
  - On an edge with `bus_stall`=0: add 4 to dst and subtract 1 from remaining. Go to DONE if remaining was 1, otherwise go to READ.
  - On an edge with `bus_stall`=1: hold.
- **DONE:** `done`=1 and `bus_drw`=00 for exactly one cycle, then IDLE. `remaining` holds its final value (0 after a normal copy).
- **Abort:** `abort`=1 in READ or WRITE moves to DONE on that edge, regardless of `bus_stall`.
  - The beat in flight is discarded; a write is not counted.
  - `remaining` keeps the count of unwritten words.
- **Pointer arithmetic:** 32-bit, modulo 2^32. Wrap from 0xFFFFFFFC to 0x00000000 is silent.
- **Overlapping ranges:** no special handling. Copying is strictly ascending, one word read then one word written.
- `start` is ignored outside IDLE, and is ignored in the DONE cycle.
- `rst`=0 mid-copy returns to IDLE on that edge. The in-flight command is dropped and `done` is not pulsed.

## Timing
- Let `start` be sampled at edge 0 with `count`=N>0 and no stalls:
  - `busy`=1 from cycle 1 through cycle 2N.
  - Reads occur in odd cycles, writes in even cycles.
  - `done`=1 in cycle 2N+1.
  - `start` is accepted again at edge 2N+2.
- Each stalled cycle adds one cycle.
- With `count`=0: `done`=1 in cycle 1.
- All outputs are registered or decoded from state and registers. No combinational path from `bus_rdata` or `bus_stall` to any output.
- Throughput is one word per two unstalled cycles.

## Structure
- Shared package `plp_bus_pkg` holds:
  - the `bus_drw` encodings `DRW_NOP`=2'b00, `DRW_WRITE`=2'b01, `DRW_READ`=2'b10;
  - the word stride constant 4;
  - the state enum.
- Single module. A sub-module is not natural at this size.

## Test plan
- **Basic copy.** Reset, then `start` with src=0x10000000, dst=0x10000100, `count`=3, zero-wait memory model holding 0xA,0xB,0xC. Expect reads at 0x10000000/04/08 and writes 0xA/0xB/0xC to 0x10000100/04/08. `done` in cycle 7; `remaining`=0.
- **Stall handling.** `count`=1 with `bus_stall`=1 for 2 cycles on the read and 1 cycle on the write. Addresses, `bus_drw` and `bus_wdata` hold steady while stalled. `done` in cycle 6.
- **Zero count and busy start.** `count`=0 gives `done` in cycle 1 and `bus_drw`=00 throughout. A second `start` pulsed mid-copy is ignored and the pointers are unchanged.
- **Abort.** `count`=4; assert `abort` during the 2nd WRITE while it is stalled. Only 1 write completes, `remaining`=3, `done` pulses once, then IDLE.
- **Wrap and alignment.** src=0xFFFFFFFE, `count`=2. Reads go to 0xFFFFFFFC then 0x00000000.
- **Reset mid-operation.** Drive `rst`=0 during READ of word 2. Next cycle all outputs are 0 and there is no `done` pulse. A new copy after reset runs normally.
